// File: rtl/spi_resp_sched.sv
// SPI response scheduler: stages one requester word for the next SPI frame and buffers received commands.
// Optional build macro SPI_RESP_SCHED_PRIO_EN gives requester 0 strict priority over a 1/2 round-robin.
module spi_resp_sched #(
    parameter logic [63:0] IDLE_WORD = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_active,
    input  logic        txn_done,
    input  logic        cmd_valid,
    input  logic [63:0] cmd_data,
    input  logic [2:0]  req_valid,
    input  logic [63:0] req_data0,
    input  logic [63:0] req_data1,
    input  logic [63:0] req_data2,
    output logic [2:0]  req_ack,
    output logic [63:0] resp_data,
    output logic        resp_staged,
    output logic        cmd_out_valid,
    output logic [63:0] cmd_out_data,
    input  logic        cmd_out_ready,
    output logic [7:0]  cmd_drop_cnt
);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_STAGED = 1'b1;

    logic        state_reg;
    logic [1:0]  rr_ptr_reg;
    logic [1:0]  grant_reg;
    logic [63:0] resp_data_reg;
    logic [2:0]  req_ack_reg;
    logic [63:0] cmd_hold_reg;
    logic        cmd_valid_reg;
    logic [7:0]  drop_cnt_reg;

    logic [1:0]  grant_next;
    logic        grant_found;
    logic [63:0] sel_word;

`ifdef SPI_RESP_SCHED_PRIO_EN
    // Requester 0 wins outright; rr_ptr only steers the choice between 1 and 2.
    always_comb begin
        grant_found = |req_valid;
        grant_next  = 2'd0;
        if (req_valid[0]) begin
            grant_next = 2'd0;
        end else if (rr_ptr_reg == 2'd2) begin
            grant_next = req_valid[2] ? 2'd2 : 2'd1;
        end else begin
            grant_next = req_valid[1] ? 2'd1 : 2'd2;
        end
    end
`else
    logic [2:0] rr_sum [3];
    logic [1:0] cand_idx [3];

    // cand_idx[k] is the requester k places after rr_ptr, modulo 3.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rot
        assign rr_sum[gi]   = {1'b0, rr_ptr_reg} + 3'(gi);
        assign cand_idx[gi] = (rr_sum[gi] >= 3'd3) ? 2'(rr_sum[gi] - 3'd3) : rr_sum[gi][1:0];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_next  = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req_valid[cand_idx[i]]) begin
                grant_found = 1'b1;
                grant_next  = cand_idx[i];
            end
        end
    end
`endif

    always_comb begin
        case (grant_next)
            2'd0:    sel_word = req_data0;
            2'd1:    sel_word = req_data1;
            default: sel_word = req_data2;
        endcase
    end

    // Response staging FSM; loads only between transactions so the shifted word never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= 2'd0;
            grant_reg     <= 2'd0;
            resp_data_reg <= IDLE_WORD;
            req_ack_reg   <= 3'b000;
        end else begin
            req_ack_reg <= 3'b000;
            if (state_reg == S_IDLE) begin
                if (!cs_active && grant_found) begin
                    grant_reg     <= grant_next;
                    resp_data_reg <= sel_word;
                    state_reg     <= S_STAGED;
                end
            end else if (txn_done && cmd_valid) begin
                req_ack_reg   <= 3'b001 << grant_reg;
                rr_ptr_reg    <= (grant_reg == 2'd2) ? 2'd0 : grant_reg + 2'd1;
                resp_data_reg <= IDLE_WORD;
                state_reg     <= S_IDLE;
            end
        end
    end

    // Single-entry command holding register; a push while full and stalled is dropped and counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_hold_reg  <= 64'h0;
            cmd_valid_reg <= 1'b0;
            drop_cnt_reg  <= 8'h00;
        end else if (cmd_valid) begin
            if (!cmd_valid_reg || cmd_out_ready) begin
                cmd_hold_reg  <= cmd_data;
                cmd_valid_reg <= 1'b1;
            end else if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end else if (cmd_out_ready) begin
            cmd_valid_reg <= 1'b0;
        end
    end

    assign resp_data     = resp_data_reg;
    assign resp_staged   = (state_reg == S_STAGED);
    assign req_ack       = req_ack_reg;
    assign cmd_out_valid = cmd_valid_reg;
    assign cmd_out_data  = cmd_hold_reg;
    assign cmd_drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_spi_resp_sched.sv
// Testbench for spi_resp_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_spi_resp_sched;

    localparam logic [63:0] TB_IDLE = 64'hCAFE_0000_0000_00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_active;
    logic        txn_done;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic [2:0]  req_valid;
    logic [63:0] req_data0, req_data1, req_data2;
    logic [2:0]  req_ack;
    logic [63:0] resp_data;
    logic        resp_staged;
    logic        cmd_out_valid;
    logic [63:0] cmd_out_data;
    logic        cmd_out_ready;
    logic [7:0]  cmd_drop_cnt;

    always #5 clk = ~clk;

    spi_resp_sched #(.IDLE_WORD(TB_IDLE)) dut (
        .clk(clk), .rst(rst), .cs_active(cs_active), .txn_done(txn_done),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .req_ack(req_ack), .resp_data(resp_data), .resp_staged(resp_staged),
        .cmd_out_valid(cmd_out_valid), .cmd_out_data(cmd_out_data),
        .cmd_out_ready(cmd_out_ready), .cmd_drop_cnt(cmd_drop_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    bit          m_staged = 0;
    logic [63:0] m_word = TB_IDLE;
    int          m_grant = 0;
    int          m_ptr = 0;
    int          m_ack = -1;
    logic [63:0] m_hold = 64'h0;
    bit          m_hv = 0;
    int          m_drop = 0;

    function automatic int model_arb();
`ifdef SPI_RESP_SCHED_PRIO_EN
        if (req_valid[0]) return 0;
        if (m_ptr == 2) return req_valid[2] ? 2 : 1;
        return req_valid[1] ? 1 : 2;
`else
        for (int k = 0; k < 3; k++)
            if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return 0;
`endif
    endfunction

    function automatic logic [63:0] req_word(int idx);
        if (idx == 0) return req_data0;
        if (idx == 1) return req_data1;
        return req_data2;
    endfunction

    function automatic logic [63:0] exp_resp();
        return m_staged ? m_word : TB_IDLE;
    endfunction

    function automatic logic [2:0] exp_ack();
        return (m_ack < 0) ? 3'b000 : 3'(1 << m_ack);
    endfunction

    // Advance model with current inputs, then clock the DUT and settle.
    task automatic tick();
        if (rst) begin
            m_staged = 0; m_ptr = 0; m_ack = -1; m_word = TB_IDLE;
            m_hold = 64'h0; m_hv = 0; m_drop = 0;
        end else begin
            m_ack = -1;
            if (!m_staged) begin
                if (!cs_active && req_valid != 3'b000) begin
                    m_grant = model_arb();
                    m_word = req_word(m_grant);
                    m_staged = 1;
                end
            end else if (txn_done && cmd_valid) begin
                m_ack = m_grant;
                m_ptr = (m_grant + 1) % 3;
                m_staged = 0;
            end
            if (cmd_valid) begin
                if (!m_hv || cmd_out_ready) begin
                    m_hold = cmd_data;
                    m_hv = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (cmd_out_ready) begin
                m_hv = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        txn_done = 0; cmd_valid = 0; req_valid = 3'b000; cs_active = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); rst = 0;
        n_vec++; if (resp_data !== TB_IDLE) begin n_bad++; $display("FAIL reset_resp got %h exp %h", resp_data, TB_IDLE); end
        n_vec++; if (resp_staged !== 1'b0 || req_ack !== 3'b000) begin n_bad++; $display("FAIL reset_stage_ack got %b/%b exp 0/000", resp_staged, req_ack); end
        n_vec++; if (cmd_out_valid !== 1'b0 || cmd_out_data !== 64'h0 || cmd_drop_cnt !== 8'h00) begin
            n_bad++; $display("FAIL reset_cmd got v=%b d=%h c=%0d exp 0/0/0", cmd_out_valid, cmd_out_data, cmd_drop_cnt);
        end
    endtask

    task automatic test_basic();
        req_valid = 3'b001; req_data0 = 64'hA5A5_0000_0000_0001; cs_active = 0; tick();
        n_vec++; if (resp_data !== 64'hA5A5_0000_0000_0001 || resp_staged !== 1'b1) begin
            n_bad++; $display("FAIL basic_stage got %h/%b exp a5a5000000000001/1", resp_data, resp_staged);
        end
        txn_done = 1; cmd_valid = 1; cmd_data = 64'h1000; tick(); clear_inputs();
        n_vec++; if (req_ack !== 3'b001 || resp_data !== TB_IDLE) begin
            n_bad++; $display("FAIL basic_ack got ack=%b resp=%h exp 001/%h", req_ack, resp_data, TB_IDLE);
        end
        tick();
        n_vec++; if (req_ack !== 3'b000) begin n_bad++; $display("FAIL basic_ack_pulse got %b exp 000", req_ack); end
    endtask

    task automatic test_short_frame();
        req_valid = 3'b010; req_data1 = 64'h11; tick();
        n_vec++; if (resp_data !== 64'h11) begin n_bad++; $display("FAIL short_stage got %h exp 11", resp_data); end
        txn_done = 1; cmd_valid = 0; tick();
        n_vec++; if (req_ack !== 3'b000 || resp_data !== 64'h11 || resp_staged !== 1'b1) begin
            n_bad++; $display("FAIL short_retain got ack=%b resp=%h st=%b exp 000/11/1", req_ack, resp_data, resp_staged);
        end
        cmd_valid = 1; cmd_data = 64'h2000; tick(); clear_inputs();
        n_vec++; if (req_ack !== 3'b010) begin n_bad++; $display("FAIL short_full_ack got %b exp 010", req_ack); end
        tick();
    endtask

    task automatic test_rr_order();
        int exp_g;
        rst = 1; tick(); rst = 0;
        req_valid = 3'b111; req_data0 = 64'hD0; req_data1 = 64'hD1; req_data2 = 64'hD2;
        for (int i = 0; i < 6; i++) begin
`ifdef SPI_RESP_SCHED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 3;
`endif
            txn_done = 0; cmd_valid = 0; tick();
            n_vec++; if (resp_data !== 64'hD0 + 64'(exp_g) || resp_staged !== 1'b1) begin
                n_bad++; $display("FAIL rr_stage[%0d] got %h/%b exp %h/1", i, resp_data, resp_staged, 64'hD0 + 64'(exp_g));
            end
            txn_done = 1; cmd_valid = 1; cmd_data = 64'(i); tick();
            n_vec++; if (req_ack !== 3'(1 << exp_g)) begin
                n_bad++; $display("FAIL rr_ack[%0d] got %b exp %b", i, req_ack, 3'(1 << exp_g));
            end
        end
        clear_inputs(); tick();
    endtask

    task automatic test_cs_block();
        rst = 1; tick(); rst = 0;
        cs_active = 1; req_valid = 3'b010; req_data1 = 64'hBEEF_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (resp_data !== TB_IDLE || resp_staged !== 1'b0) begin
                n_bad++; $display("FAIL cs_hold[%0d] got %h/%b exp %h/0", i, resp_data, resp_staged, TB_IDLE);
            end
        end
        cs_active = 0; tick();
        n_vec++; if (resp_data !== 64'hBEEF_0001) begin n_bad++; $display("FAIL cs_release got %h exp beef0001", resp_data); end
        txn_done = 1; cmd_valid = 1; tick(); clear_inputs(); tick();
    endtask

    task automatic test_cmd_sat();
        rst = 1; tick(); rst = 0;
        cmd_out_ready = 0;
        for (int i = 0; i < 258; i++) begin
            txn_done = 1; cmd_valid = 1; cmd_data = 64'h5000 + 64'(i); tick();
        end
        clear_inputs();
        n_vec++; if (cmd_out_data !== 64'h5000 || cmd_out_valid !== 1'b1) begin
            n_bad++; $display("FAIL sat_hold got %h/%b exp 5000/1", cmd_out_data, cmd_out_valid);
        end
        n_vec++; if (cmd_drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_count got %0d exp 255", cmd_drop_cnt); end
        cmd_valid = 1; txn_done = 1; cmd_data = 64'h7777; cmd_out_ready = 1; tick();
        n_vec++; if (cmd_out_data !== 64'h7777 || cmd_out_valid !== 1'b1 || cmd_drop_cnt !== 8'd255) begin
            n_bad++; $display("FAIL sat_pushpop got %h/%b/%0d exp 7777/1/255", cmd_out_data, cmd_out_valid, cmd_drop_cnt);
        end
        cmd_valid = 0; txn_done = 0; tick();
        n_vec++; if (cmd_out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_drain got %b exp 0", cmd_out_valid); end
        cmd_out_ready = 0;
    endtask

    task automatic test_reset_mid();
        rst = 1; tick(); rst = 0;
        req_valid = 3'b010; req_data1 = 64'hE1; tick();
        txn_done = 1; cmd_valid = 1; tick();
        txn_done = 0; cmd_valid = 0; req_valid = 3'b100; req_data2 = 64'hE2; tick();
        n_vec++; if (resp_data !== 64'hE2) begin n_bad++; $display("FAIL rstmid_stage got %h exp e2", resp_data); end
        rst = 1; txn_done = 1; cmd_valid = 1; tick(); rst = 0;
        n_vec++; if (req_ack !== 3'b000 || resp_staged !== 1'b0 || resp_data !== TB_IDLE) begin
            n_bad++; $display("FAIL rstmid_discard got ack=%b st=%b resp=%h exp 000/0/%h", req_ack, resp_staged, resp_data, TB_IDLE);
        end
        txn_done = 0; cmd_valid = 0; req_valid = 3'b111; req_data0 = 64'hE0; tick();
        n_vec++; if (resp_data !== 64'hE0) begin n_bad++; $display("FAIL rstmid_ptr got %h exp e0", resp_data); end
        txn_done = 1; cmd_valid = 1; tick(); clear_inputs(); tick();
    endtask

    task automatic test_random();
        bit [2:0] pend = 3'b000;
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && $urandom_range(3) == 0) begin
                    pend[k] = 1'b1;
                    if (k == 0) req_data0 = {$urandom, $urandom};
                    else if (k == 1) req_data1 = {$urandom, $urandom};
                    else req_data2 = {$urandom, $urandom};
                end
            end
            req_valid     = pend;
            cs_active     = ($urandom_range(1) == 1);
            txn_done      = ($urandom_range(3) == 0);
            cmd_valid     = txn_done && ($urandom_range(2) != 0);
            cmd_data      = {$urandom, $urandom};
            cmd_out_ready = ($urandom_range(3) == 0);
            rst           = ($urandom_range(299) == 0);
            tick();
            n_vec++; if (resp_data !== exp_resp()) begin n_bad++; $display("FAIL rand_resp c=%0d got %h exp %h", c, resp_data, exp_resp()); end
            n_vec++; if (resp_staged !== m_staged) begin n_bad++; $display("FAIL rand_staged c=%0d got %b exp %b", c, resp_staged, m_staged); end
            n_vec++; if (req_ack !== exp_ack()) begin n_bad++; $display("FAIL rand_ack c=%0d got %b exp %b", c, req_ack, exp_ack()); end
            n_vec++; if (cmd_out_valid !== m_hv) begin n_bad++; $display("FAIL rand_cmdv c=%0d got %b exp %b", c, cmd_out_valid, m_hv); end
            n_vec++; if (cmd_out_data !== m_hold) begin n_bad++; $display("FAIL rand_cmdd c=%0d got %h exp %h", c, cmd_out_data, m_hold); end
            n_vec++; if (cmd_drop_cnt !== 8'(m_drop)) begin n_bad++; $display("FAIL rand_drop c=%0d got %0d exp %0d", c, cmd_drop_cnt, m_drop); end
            if (m_ack >= 0) pend[m_ack] = 1'b0;
        end
        rst = 0; clear_inputs(); cmd_out_ready = 0;
    endtask

    initial begin
        rst = 1; cs_active = 0; txn_done = 0; cmd_valid = 0; cmd_data = 64'h0;
        req_valid = 3'b000; req_data0 = 64'h0; req_data1 = 64'h0; req_data2 = 64'h0;
        cmd_out_ready = 0;
        test_reset();
        test_basic();
        test_short_frame();
        test_rr_order();
        test_cs_block();
        test_cmd_sat();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
